mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesting cores; ADDR_W, default 8, data-memory word address width; DATA_W, default 16, data word width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-core access request.
REQ-006 req_we  input  NUM_REQ  per-core write enable (1=store, 0=load).
REQ-007 req_addr  input  NUM_REQ*ADDR_W  per-core word address, core i at bits [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  input  NUM_REQ*DATA_W  per-core store data, same packing.
REQ-009 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-010 rsp_valid  output  NUM_REQ  one-hot completion pulse.
REQ-011 rsp_rdata  output  DATA_W  load data for the completing core.
REQ-012 mem_en, mem_we  output  1 each  data-memory access strobe and write enable.
REQ-013 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address and store data.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on handshake, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 In IDLE, the winner SHALL be the first asserted req_valid bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0; req_ready SHALL be the winner's one-hot bit, combinationally, only in IDLE.
REQ-017 Handshake = req_valid[i] & req_ready[i]; on it, the block SHALL latch i, req_we[i], req_addr[i], req_wdata[i], and set rr_ptr = (i+1) mod NUM_REQ.
REQ-018 In ISSUE, mem_en SHALL be 1 for exactly one cycle, with mem_we/mem_addr/mem_wdata from the latched values.
REQ-019 In RESP, rsp_valid[granted] SHALL pulse for exactly one cycle; rsp_rdata SHALL be registered from mem_rdata on the ISSUE->RESP edge for loads, 0 for stores, and held until the next RESP.
REQ-020 Latency SHALL be fixed: handshake in cycle T, mem_en in T+1, rsp_valid in T+2; throughput one access per 3 cycles.
REQ-021 mem_en SHALL be 0 and mem_we/mem_addr/mem_wdata SHALL be 0 outside ISSUE.
REQ-022 req_ready and rsp_valid SHALL each be zero or one-hot every cycle.
REQ-023 No req_valid in IDLE: the block SHALL stay in IDLE and rr_ptr SHALL be unchanged.
REQ-024 Requesters hold valid and fields stable until ready; a req_valid dropped before ready SHALL have no effect. Inputs SHALL be ignored outside IDLE.
REQ-025 A core SHALL wait at most NUM_REQ-1 other grants between asserting req_valid and its handshake.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, rr_ptr 0, latched fields 0, rsp_rdata 0, all outputs 0.
REQ-027 Reset asserted in ISSUE or RESP SHALL abandon the access with no rsp_valid; after release the core re-requests, and the first grant uses rr_ptr 0.

Verification
REQ-028 Single load: core 2 load addr 5, mem[5]=100 -> req_ready=0100 cycle T, mem_en=1 mem_addr=5 at T+1, rsp_valid=0100 rsp_rdata=100 at T+2.
REQ-029 Single store: core 1 store 15 to addr 0 -> mem_we=1 mem_addr=0 mem_wdata=15 at T+1; rsp_valid=0010 rsp_rdata=0 at T+2.
REQ-030 Round-robin: all four cores request continuously from reset -> grant order 0,1,2,3,0, one grant per 3 cycles.
REQ-031 Fairness: cores 0 and 3 continuous, after 0 granted -> next grant 3, then 0; no core skipped.
REQ-032 Reset mid-access: reset=0 during ISSUE -> mem_en=0 same cycle, no rsp_valid; after release core 3 alone -> granted normally and rr_ptr becomes 0 (wrap).
REQ-033 Idle: no req_valid for 10 cycles -> mem_en, req_ready, rsp_valid remain 0 and next grant follows the prior rr_ptr.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets NUM_REQ cores share one data-memory port.
// Each access takes three cycles: grant (IDLE), memory strobe (ISSUE),
// completion pulse with load data (RESP).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | searching for a requester from rr_ptr upward; grant on handshake
// ISSUE | drive the latched access onto the memory port for one cycle
// RESP  | pulse rsp_valid for the granted core, rsp_rdata already captured
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic                handshake;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [IDX_W:0]      cand;
  logic [IDX_W-1:0]    cand_idx;

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant only in IDLE; reset gating keeps req_ready low while reset is held.
  assign handshake = (state == IDLE) && win_found && reset;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and all combinational outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (handshake) begin
          req_ready[win_idx] = 1'b1;
          state_nxt          = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt_idx] = 1'b1;
        state_nxt          = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winner's request and advance the round-robin pointer past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (handshake) begin
      gnt_idx   <= win_idx;
      lat_we    <= req_we[win_idx];
      lat_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
      lat_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
      if (win_idx == IDX_W'(NUM_REQ-1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= win_idx + 1'b1;
      end
    end
  end

  // Capture load data as ISSUE ends; stores complete with zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
    end else if (state == ISSUE) begin
      rsp_rdata <= lat_we ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   mem [0:255];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int core;
    int cyc;
  } gnt_t;
  gnt_t log_q[$];

  // model state: one outstanding transaction described by its grant cycle
  int m_rr = 0;
  int m_g_cycle = -10;
  int m_g_core = 0;
  int m_we = 0;
  int m_addr = 0;
  int m_wdata = 0;
  int m_rdata = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_en ? mem[mem_addr] : '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    int exp_ready;
    int exp_rsp;
    int w;
    bit issue;
    bit resp;
    cyc++;
    if (reset !== 1'b1) begin
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      m_rr = 0;
      m_g_cycle = -10;
      m_rdata = 0;
    end else begin
      exp_ready = 0;
      w = -1;
      if (cyc - m_g_cycle >= 3) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        if (w >= 0) exp_ready = 1 << w;
      end
      issue = (cyc == m_g_cycle + 1);
      resp  = (cyc == m_g_cycle + 2);
      exp_rsp = resp ? (1 << m_g_core) : 0;
      check("req_ready", 32'(req_ready), exp_ready);
      check("mem_en", 32'(mem_en), 32'(issue));
      check("mem_we", 32'(mem_we), issue ? m_we : 0);
      check("mem_addr", 32'(mem_addr), issue ? m_addr : 0);
      check("mem_wdata", 32'(mem_wdata), issue ? m_wdata : 0);
      check("rsp_valid", 32'(rsp_valid), exp_rsp);
      check("rsp_rdata", 32'(rsp_rdata), m_rdata);
      if (req_ready != '0) begin
        gnt_t g;
        g.core = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g.core = i;
        g.cyc = cyc;
        log_q.push_back(g);
      end
      if (issue) m_rdata = m_we ? 0 : int'(mem[m_addr]);
      if (w >= 0) begin
        m_g_cycle = cyc;
        m_g_core  = w;
        m_we      = int'(req_we[w]);
        m_addr    = int'(req_addr[w*AW +: AW]);
        m_wdata   = int'(req_wdata[w*DW +: DW]);
        m_rr      = (w + 1) % N;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request from one core; returns after the handshake edge, valid dropped.
  task automatic do_single(int core, bit we, int addr, int wdata, logic [N-1:0] exp_ready);
    bit seen = 0;
    req_we[core] = we;
    req_addr[core*AW +: AW] = AW'(addr);
    req_wdata[core*DW +: DW] = DW'(wdata);
    req_valid[core] = 1'b1;
    for (int b = 0; b < 20 && !seen; b++) begin
      @(negedge clk);
      if (req_ready[core]) seen = 1;
    end
    check("single_grant_seen", 32'(seen), 1);
    check("single_ready_vec", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    req_valid[core] = 1'b0;
  endtask

  // Continuous loads from every core in mask until n grants are logged.
  task automatic run_cont(logic [N-1:0] mask, int n);
    int b = 0;
    log_q.delete();
    for (int i = 0; i < N; i++) begin
      req_we[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(20 + i);
    end
    req_valid = mask;
    while (log_q.size() < n && b < 60) begin
      @(posedge clk);
      b++;
    end
    #1;
    req_valid = '0;
    check("cont_grant_count", 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i * 7 + 3);
    mem[5] = 16'd100;

    // reset holds everything low even with requests present
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("reset_ready_gated", 32'(req_ready), 0);
    check("reset_mem_en", 32'(mem_en), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    reset = 1'b1;
    tick(2);

    // single load: core 2, addr 5
    do_single(2, 0, 5, 0, 4'b0100);
    @(negedge clk);
    check("load_mem_en", 32'(mem_en), 1);
    check("load_mem_addr", 32'(mem_addr), 5);
    check("load_mem_we", 32'(mem_we), 0);
    @(negedge clk);
    check("load_rsp_valid", 32'(rsp_valid), 32'h4);
    check("load_rsp_rdata", 32'(rsp_rdata), 100);
    tick(1);

    // single store: core 1 writes 15 to addr 0
    do_single(1, 1, 0, 15, 4'b0010);
    @(negedge clk);
    check("store_mem_we", 32'(mem_we), 1);
    check("store_mem_addr", 32'(mem_addr), 0);
    check("store_mem_wdata", 32'(mem_wdata), 15);
    @(negedge clk);
    check("store_rsp_valid", 32'(rsp_valid), 32'h2);
    check("store_rsp_rdata", 32'(rsp_rdata), 0);
    tick(1);

    // read the stored word back through core 0
    do_single(0, 0, 0, 0, 4'b0001);
    repeat (2) @(negedge clk);
    check("readback_rdata", 32'(rsp_rdata), 15);
    tick(1);

    // reset while idle brings rr_ptr back to 0
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);

    // all four continuous: 0,1,2,3,0 every 3 cycles
    run_cont(4'b1111, 5);
    if (log_q.size() == 5) begin
      check("rr_g0", 32'(log_q[0].core), 0);
      check("rr_g1", 32'(log_q[1].core), 1);
      check("rr_g2", 32'(log_q[2].core), 2);
      check("rr_g3", 32'(log_q[3].core), 3);
      check("rr_g4", 32'(log_q[4].core), 0);
      for (int i = 1; i < 5; i++) check("rr_spacing", 32'(log_q[i].cyc - log_q[i-1].cyc), 3);
    end
    tick(3);

    // cores 0 and 3 continuous, pointer at 1: 3,0,3,0
    run_cont(4'b1001, 4);
    if (log_q.size() == 4) begin
      check("fair_g0", 32'(log_q[0].core), 3);
      check("fair_g1", 32'(log_q[1].core), 0);
      check("fair_g2", 32'(log_q[2].core), 3);
      check("fair_g3", 32'(log_q[3].core), 0);
    end
    tick(3);

    // ten idle cycles, then pointer (still 1) picks core 2 over core 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 0);
      check("idle_mem_en", 32'(mem_en), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
    end
    tick(1);
    run_cont(4'b0101, 1);
    if (log_q.size() == 1) check("idle_next_grant", 32'(log_q[0].core), 2);
    tick(3);

    // reset during ISSUE abandons the access
    do_single(1, 0, 9, 0, 4'b0010);
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    check("abort_rsp_valid2", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    do_single(3, 0, 7, 0, 4'b1000);
    @(negedge clk);
    check("post_rst_mem_addr", 32'(mem_addr), 7);
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'h8);
    check("post_rst_rdata", 32'(rsp_rdata), 52);
    tick(1);
    run_cont(4'b1001, 1);
    if (log_q.size() == 1) check("wrap_grant", 32'(log_q[0].core), 0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
